// File: rtl/imm_narrower.sv
// Narrows 16-bit immediates into a byte stream: one short byte when the value
// sign-extends from its low byte, otherwise high byte then low byte.
module imm_narrower #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_short,
  output logic [CNT_W-1:0] short_count,
  output logic [CNT_W-1:0] long_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHORT = 2'd1;
  localparam logic [1:0] HI    = 2'd2;
  localparam logic [1:0] LO    = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [15:0]      word_q, word_d;
  logic [CNT_W-1:0] short_cnt_q, short_cnt_d;
  logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
  logic             in_xfer, out_xfer;

  function automatic logic fits_byte(input logic [15:0] w);
    return w[15:8] == {8{w[7]}};
  endfunction

  function automatic logic [1:0] entry_state(input logic [15:0] w);
    return fits_byte(w) ? SHORT : HI;
  endfunction

  // Outputs are pure decodes of state and the held word, so they stay stable
  // under back-pressure; in IDLE the low byte of the last word remains visible.
  assign out_valid   = (state_q != IDLE);
  assign out_last    = (state_q == SHORT) || (state_q == LO);
  assign out_short   = (state_q == SHORT);
  assign out         = (state_q == HI) ? word_q[15:8] : word_q[7:0];
  assign short_count = short_cnt_q;
  assign long_count  = long_cnt_q;

  assign in_ready = !reset && ((state_q == IDLE) || (out_valid && out_last && out_ready));
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    short_cnt_d = short_cnt_q;
    long_cnt_d  = long_cnt_q;
    case (state_q)
      IDLE:      if (in_xfer) state_d = entry_state(in);
      SHORT, LO: if (out_xfer) state_d = in_xfer ? entry_state(in) : IDLE;
      HI:        if (out_xfer) state_d = LO;
      default:   state_d = IDLE;
    endcase
    if (in_xfer) word_d = in;
    if (out_xfer && (state_q == SHORT)) short_cnt_d = short_cnt_q + CNT_W'(1);
    if (out_xfer && (state_q == LO))    long_cnt_d  = long_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      short_cnt_q <= '0;
      long_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      short_cnt_q <= short_cnt_d;
      long_cnt_q  <= long_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_narrower.sv
// Bench for imm_narrower: table vectors, hand-written corner sequences and a
// randomized stream checked against a byte-queue reference model.
module tb_imm_narrower;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] din = 16'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        out_short;
  logic [7:0]  short_count;
  logic [7:0]  long_count;

  imm_narrower #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_short(out_short), .short_count(short_count), .long_count(long_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
    logic       shrt;
  } exp_t;

  typedef struct {
    logic [15:0] w;
    bit          lng;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  exp_t exp_q[$];
  int   xcyc[$];
  int   checks = 0;
  int   fails = 0;
  int   exp_short = 0;
  int   exp_long = 0;
  int   cyc = 0;
  int   rdy_mode = 3;  // 0: low, 1: high, 2: random, 3: manual
  bit   stall_prev = 0;
  logic [7:0] prev_out;
  logic prev_last, prev_short;
  vec_t vt[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: a word whose signed value lies in a byte's range is one short byte.
  task automatic push_model(input logic [15:0] w);
    int v;
    v = int'($signed(w));
    if (v >= -128 && v <= 127) exp_q.push_back('{w[7:0], 1'b1, 1'b1});
    else begin
      exp_q.push_back('{w[15:8], 1'b0, 1'b0});
      exp_q.push_back('{w[7:0], 1'b1, 1'b0});
    end
  endtask

  task automatic push_vec(input vec_t v);
    if (v.lng) begin
      exp_q.push_back('{v.hi, 1'b0, 1'b0});
      exp_q.push_back('{v.lo, 1'b1, 1'b0});
    end else exp_q.push_back('{v.lo, 1'b1, 1'b1});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = 1'b0;
      1: out_ready = 1'b1;
      2: out_ready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  end

  // Output monitor: every transferred byte must be the next one the model predicts.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (!out_last) chk("hi_in_ready", {31'b0, in_ready}, 32'd0);
      if (stall_prev) begin
        chk("hold_out", {24'b0, out}, {24'b0, prev_out});
        chk("hold_last_short", {30'b0, out_last, out_short}, {30'b0, prev_last, prev_short});
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_byte actual=%0h required=none", out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("byte", {24'b0, out}, {24'b0, e.b});
          chk("last", {31'b0, out_last}, {31'b0, e.last});
          chk("short", {31'b0, out_short}, {31'b0, e.shrt});
          if (e.last) begin
            if (e.shrt) exp_short++;
            else exp_long++;
          end
        end
        xcyc.push_back(cyc);
      end
      stall_prev = !out_ready;
      prev_out   = out;
      prev_last  = out_last;
      prev_short = out_short;
    end else stall_prev = 0;
  end

  task automatic send_word(input logic [15:0] w);
    din = w;
    in_valid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL accept_timeout actual=no_in_ready required=in_ready word=%0h", w);
  endtask

  task automatic idle_cycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    checks++;
    fails++;
    $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    exp_q.delete();
    exp_short = 0;
    exp_long = 0;
    stall_prev = 0;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] b;
    logic [15:0] w;
    vt[0] = '{16'h007F, 0, 8'h00, 8'h7F};
    vt[1] = '{16'hFF80, 0, 8'h00, 8'h80};
    vt[2] = '{16'h0000, 0, 8'h00, 8'h00};
    vt[3] = '{16'hFFFF, 0, 8'h00, 8'hFF};
    vt[4] = '{16'h0080, 1, 8'h00, 8'h80};
    vt[5] = '{16'hFF7F, 1, 8'hFF, 8'h7F};
    vt[6] = '{16'h0001, 0, 8'h00, 8'h01};
    vt[7] = '{16'h0100, 1, 8'h01, 8'h00};
    vt[8] = '{16'hFFFE, 0, 8'h00, 8'hFE};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out", {24'b0, out}, 32'h0);
    chk("rst_last_short", {30'b0, out_last, out_short}, 32'd0);
    chk("rst_short_count", {24'b0, short_count}, 32'd0);
    chk("rst_long_count", {24'b0, long_count}, 32'd0);
    reset = 1'b0;

    // Reset while presenting the low byte of 0xABCD
    rdy_mode = 3;
    out_ready = 1'b0;
    push_model(16'hABCD);
    send_word(16'hABCD);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("lo_before_reset", {24'b0, out}, 32'hCD);
    out_ready = 1'b0;
    do_reset();
    chk("lo_rst_short_count", {24'b0, short_count}, 32'd0);
    chk("lo_rst_long_count", {24'b0, long_count}, 32'd0);
    rdy_mode = 1;
    push_model(16'h0005);
    send_word(16'h0005);
    drain();
    chk("after_rst_short_count", {24'b0, short_count}, 32'd1);
    chk("after_rst_long_count", {24'b0, long_count}, 32'd0);

    // Table vectors: shorts back-to-back, longs back-to-back, mixed with random ready
    do_reset();
    rdy_mode = 1;
    @(posedge clk);
    #1;
    xcyc.delete();
    for (int i = 0; i < 4; i++) begin
      push_vec(vt[i]);
      send_word(vt[i].w);
    end
    drain();
    chk("short_nbytes", xcyc.size(), 4);
    if (xcyc.size() == 4) chk("short_thru", xcyc[3] - xcyc[0], 3);
    chk("short_count4", {24'b0, short_count}, 32'd4);
    xcyc.delete();
    for (int i = 4; i < 6; i++) begin
      push_vec(vt[i]);
      send_word(vt[i].w);
    end
    drain();
    chk("long_nbytes", xcyc.size(), 4);
    if (xcyc.size() == 4) chk("long_thru", xcyc[3] - xcyc[0], 3);
    chk("long_count2", {24'b0, long_count}, 32'd2);
    rdy_mode = 2;
    for (int i = 6; i < 9; i++) begin
      push_vec(vt[i]);
      send_word(vt[i].w);
    end
    drain();
    chk("mixed_short_count", {24'b0, short_count}, 32'd6);
    chk("mixed_long_count", {24'b0, long_count}, 32'd3);

    // Back-pressure on 0x1234
    rdy_mode = 3;
    out_ready = 1'b0;
    push_model(16'h1234);
    send_word(16'h1234);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out", {24'b0, out}, 32'h12);
      chk("bp_valid_ready", {30'b0, out_valid, in_ready}, 32'd2);
    end
    @(posedge clk);
    #1;
    rdy_mode = 1;
    out_ready = 1'b1;
    drain();
    chk("bp_long_count", {24'b0, long_count}, 32'd4);

    // Short counter wrap
    do_reset();
    rdy_mode = 1;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      w = {{8{b[7]}}, b};
      push_model(w);
      send_word(w);
      if (i == 254) begin
        drain();
        chk("short_count255", {24'b0, short_count}, 32'd255);
      end
    end
    drain();
    chk("wrap_short_count", {24'b0, short_count}, 32'd0);
    chk("wrap_long_count", {24'b0, long_count}, 32'd0);

    // Randomized stream against the model
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 1) w = 16'($urandom_range(0, 255)) - 16'd128;
      else w = 16'($urandom);
      push_model(w);
      send_word(w);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end
    drain();
    chk("rand_short_count", {24'b0, short_count}, {24'b0, 8'(exp_short)});
    chk("rand_long_count", {24'b0, long_count}, {24'b0, 8'(exp_long)});
    chk("rand_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
